// File: rtl/regfile_pkg.sv
// Register-file shared definitions: geometry, address/data types and the
// occupancy encoding of the read-port output buffer.
package regfile_pkg;

    localparam int unsigned REG_W      = 64;
    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_data_t;

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(0);

    // Output buffer occupancy.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/regfile_read_port_if.sv
// Read request / response channel of the register file.
// master: consumer (issues req_*, accepts rsp_*); slave: the read port.
//   req_valid/req_ready/req_addr : request handshake and address
//   rsp_valid/rsp_ready          : response handshake
//   rsp_addr/rsp_data            : address the response belongs to, read data
interface regfile_read_port_if
    import regfile_pkg::*;
#(
    parameter int unsigned N      = REG_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [N-1:0]      rsp_data;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_data
    );
endinterface

// File: rtl/rf_skid_buffer.sv
// Two-entry valid/ready buffer. The head entry drives the registered output;
// a second (skid) entry absorbs one push while the head is stalled.
//   clock, reset         : clock, async active-low reset
//   in_valid, in_data    : push (caller only pushes when full == 0)
//   full                 : registered, both entries occupied
//   full_nxt_c           : combinational, full after the coming edge
//   out_valid, out_data  : registered head entry
//   out_ready            : consumer takes the head this cycle
module rf_skid_buffer
    import regfile_pkg::*;
#(
    parameter int unsigned W = REG_ADDR_W + REG_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         full,
    output logic         full_nxt_c,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    buf_state_e   state;
    buf_state_e   state_nxt;
    logic [W-1:0] skid;
    logic [W-1:0] skid_nxt;
    logic [W-1:0] head_nxt;
    logic         pop;

    assign pop        = out_valid & out_ready;
    assign full_nxt_c = (state_nxt == BUF_FULL);

    // Occupancy state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Entry storage and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
        end else begin
            skid      <= skid_nxt;
            out_data  <= head_nxt;
            out_valid <= (state_nxt != BUF_EMPTY);
            full      <= (state_nxt == BUF_FULL);
        end
    end

    // Next occupancy and entry contents; the head only changes on a pop or
    // when empty, which keeps the output stable while stalled.
    always_comb begin
        state_nxt = state;
        head_nxt  = out_data;
        skid_nxt  = skid;
        case (state)
            BUF_EMPTY: begin
                if (in_valid) begin
                    head_nxt  = in_data;
                    state_nxt = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (pop && in_valid) begin
                    head_nxt = in_data;
                end else if (pop) begin
                    state_nxt = BUF_EMPTY;
                end else if (in_valid) begin
                    skid_nxt  = in_data;
                    state_nxt = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    head_nxt  = skid;
                    state_nxt = BUF_ONE;
                end
            end
            default: begin
                state_nxt = BUF_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/regfile_read_port.sv
// Pipelined, flow-controlled register-file read port. An accepted address
// sits in S1 for one select cycle, where the register is muxed out of reg_bus
// (with same-cycle write forwarding); the result then enters a 2-entry output
// buffer whose head drives the response channel.
//   clock, reset        : clock, async active-low reset
//   reg_bus             : all register contents, reg k at [k*N +: N]
//   wr_load/addr/data   : write side, commits at the next rising edge
//   rd (slave)          : request/response channel
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned N        = REG_W,
    parameter int unsigned REGS     = REG_COUNT,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REGS*N-1:0] reg_bus,
    input  logic              wr_load,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    regfile_read_port_if.slave rd
);

    localparam int unsigned PW = ADDR_W + N;

    logic              s1_valid;
    logic              s1_valid_nxt;
    logic [ADDR_W-1:0] s1_addr;
    logic              req_ready_q;
    logic              req_fire;
    logic              adv;
    logic              buf_full;
    logic              buf_full_nxt_c;
    logic [N-1:0]      sel_data;
    logic [PW-1:0]     rsp_payload;

    assign req_fire     = rd.req_valid & req_ready_q;
    // S1 drains whenever the buffer has a free entry.
    assign adv          = s1_valid & ~buf_full;
    assign s1_valid_nxt = req_fire | (s1_valid & ~adv);

    // S1 address stage and registered request-ready. Ready is withheld only
    // when S1 and both buffer entries will all be occupied after this edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            req_ready_q <= 1'b0;
        end else begin
            s1_valid    <= s1_valid_nxt;
            if (req_fire) begin
                s1_addr <= rd.req_addr;
            end
            req_ready_q <= ~(s1_valid_nxt & buf_full_nxt_c);
        end
    end

    // Select mux: later overrides win (zero register and out-of-range beat bypass).
    always_comb begin
        sel_data = reg_bus[32'(s1_addr) * N +: N];
        if (wr_load && (wr_addr == s1_addr)) begin
            sel_data = wr_data;
        end
        if ((ZERO_REG != 0) && (s1_addr == ADDR_W'(ZERO_ADDR))) begin
            sel_data = '0;
        end
        if (32'(s1_addr) >= REGS) begin
            sel_data = '0;
        end
    end

    rf_skid_buffer #(
        .W (PW)
    ) u_buf (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (adv),
        .in_data    ({s1_addr, sel_data}),
        .full       (buf_full),
        .full_nxt_c (buf_full_nxt_c),
        .out_valid  (rd.rsp_valid),
        .out_data   (rsp_payload),
        .out_ready  (rd.rsp_ready)
    );

    assign rd.req_ready = req_ready_q;
    assign rd.rsp_addr  = rsp_payload[PW-1 -: ADDR_W];
    assign rd.rsp_data  = rsp_payload[N-1:0];

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed scenarios plus randomized traffic,
// checked against a request-queue model of the read port.
module tb_regfile_read_port;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        int          edge_no;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [2047:0] reg_bus;
    logic          wr_load;
    logic [4:0]    wr_addr;
    logic [63:0]   wr_data;
    logic [63:0]   regs [32];

    int   vectors;
    int   miscompares;
    int   edge_cnt;
    int   max_inflight;
    exp_t q [$];
    logic armed;
    logic sel_pending;
    logic lat_check;
    logic held;
    logic [4:0]  held_addr;
    logic [63:0] held_data;
    logic last_req_fire;

    regfile_read_port_if #(.N(64), .ADDR_W(5)) rd ();

    regfile_read_port dut (
        .clock   (clk),
        .reset   (rst_n),
        .reg_bus (reg_bus),
        .wr_load (wr_load),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd      (rd)
    );

    for (genvar k = 0; k < 32; k++) begin : g_bus
        assign reg_bus[k*64 +: 64] = regs[k];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a read of addr returns when its select cycle is the current cycle.
    function automatic logic [63:0] exp_value(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (wr_load && wr_addr == a) return wr_data;
        return regs[a];
    endfunction

    // One clock cycle: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        exp_t        e;
        logic        rsp_fire;
        logic        req_fire;
        logic        wl;
        logic [4:0]  wa;
        logic [63:0] wd;
        @(negedge clk);
        if (sel_pending && q.size() > 0) begin
            e = q.pop_back();
            e.data = exp_value(e.addr);
            q.push_back(e);
        end
        vectors++;
        if (rd.req_ready !== ((armed && q.size() < 3) ? 1'b1 : 1'b0)) begin
            miscompares++;
            $display("FAIL req_ready: got %b want %b (in flight %0d)", rd.req_ready,
                     (armed && q.size() < 3), q.size());
        end
        if (held) begin
            vectors++;
            if (rd.rsp_valid !== 1'b1 || rd.rsp_addr !== held_addr || rd.rsp_data !== held_data) begin
                miscompares++;
                $display("FAIL rsp_stable: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                         rd.rsp_valid, rd.rsp_addr, rd.rsp_data, held_addr, held_data);
            end
        end
        if (rd.rsp_valid === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_spurious: got a=%0d d=%h want no response", rd.rsp_addr, rd.rsp_data);
            end else if (rd.rsp_addr !== q[0].addr || rd.rsp_data !== q[0].data) begin
                miscompares++;
                $display("FAIL rsp_payload: got a=%0d d=%h want a=%0d d=%h",
                         rd.rsp_addr, rd.rsp_data, q[0].addr, q[0].data);
            end
            if (lat_check && rd.rsp_ready && q.size() > 0) begin
                vectors++;
                if (edge_cnt + 1 - q[0].edge_no != 2) begin
                    miscompares++;
                    $display("FAIL latency: got %0d edges want 2", edge_cnt + 1 - q[0].edge_no);
                end
            end
        end
        rsp_fire  = (rd.rsp_valid === 1'b1) && rd.rsp_ready;
        req_fire  = rd.req_valid && (rd.req_ready === 1'b1);
        held      = (rd.rsp_valid === 1'b1) && !rd.rsp_ready;
        held_addr = rd.rsp_addr;
        held_data = rd.rsp_data;
        wl = wr_load;
        wa = wr_addr;
        wd = wr_data;
        @(posedge clk);
        edge_cnt++;
        if (rsp_fire && q.size() > 0) void'(q.pop_front());
        if (req_fire) begin
            e.addr    = rd.req_addr;
            e.data    = '0;
            e.edge_no = edge_cnt;
            q.push_back(e);
        end
        sel_pending   = req_fire;
        last_req_fire = req_fire;
        armed         = 1'b1;
        if (q.size() > max_inflight) max_inflight = q.size();
        #1;
        if (wl) regs[wa] = wd;
    endtask

    task automatic drain();
        rd.req_valid = 1'b0;
        rd.rsp_ready = 1'b1;
        wr_load      = 1'b0;
        for (int i = 0; i < 20 && (q.size() != 0 || rd.rsp_valid === 1'b1); i++) tick();
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d responses outstanding want 0", q.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        vectors++;
        if (rd.req_ready !== 1'b0 || rd.rsp_valid !== 1'b0 || rd.rsp_addr !== 5'd0 || rd.rsp_data !== 64'd0) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b v=%b a=%0d d=%h want all 0", name,
                     rd.req_ready, rd.rsp_valid, rd.rsp_addr, rd.rsp_data);
        end
    endtask

    task automatic model_reset();
        q.delete();
        armed       = 1'b0;
        sel_pending = 1'b0;
        held        = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        rd.req_valid = 1'b0;
        rd.req_addr  = '0;
        rd.rsp_ready = 1'b0;
        wr_load      = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        for (int k = 0; k < 32; k++) regs[k] = {$urandom, $urandom};
        model_reset();
        #12;
        check_outputs_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single_read();
        regs[5]      = 64'h0000_0000_DEAD_BEEF;
        lat_check    = 1'b1;
        rd.rsp_ready = 1'b1;
        rd.req_valid = 1'b1;
        rd.req_addr  = 5'd5;
        tick();
        rd.req_valid = 1'b0;
        vectors++;
        if (last_req_fire !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept: got %b want 1", last_req_fire);
        end
        drain();
        lat_check = 1'b0;
    endtask

    task automatic test_bypass();
        regs[7]      = {$urandom, $urandom};
        rd.rsp_ready = 1'b1;
        rd.req_valid = 1'b1;
        rd.req_addr  = 5'd7;
        tick();
        rd.req_valid = 1'b0;
        rd.rsp_ready = 1'b0;
        wr_load      = 1'b1;
        wr_addr      = 5'd7;
        wr_data      = 64'h1234;
        tick();
        // later writes to reg 7 must not disturb the captured result
        wr_data = 64'h5555_AAAA_5555_AAAA;
        tick();
        wr_data = 64'hFFFF_0000_FFFF_0000;
        tick();
        drain();
    endtask

    task automatic test_zero_reg();
        rd.rsp_ready = 1'b1;
        rd.req_valid = 1'b1;
        rd.req_addr  = 5'd0;
        wr_load      = 1'b1;
        wr_addr      = 5'd0;
        wr_data      = '1;
        tick();
        rd.req_valid = 1'b0;
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        int n;
        n            = 1;
        max_inflight = 0;
        for (int c = 0; c < 60 && (n <= 6 || q.size() != 0); c++) begin
            rd.rsp_ready = !(c >= 3 && c <= 8);
            rd.req_valid = (n <= 6);
            rd.req_addr  = 5'(n);
            tick();
            if (last_req_fire) n++;
        end
        vectors++;
        if (n != 7) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d want 6", n - 1);
        end
        vectors++;
        if (max_inflight != 3) begin
            miscompares++;
            $display("FAIL bp_capacity: got %0d in flight want 3", max_inflight);
        end
        drain();
    endtask

    task automatic test_streaming();
        int n;
        int cycles;
        n            = 0;
        cycles       = 0;
        lat_check    = 1'b1;
        rd.rsp_ready = 1'b1;
        rd.req_valid = 1'b1;
        for (int c = 0; c < 80 && n < 32; c++) begin
            rd.req_addr = 5'(n);
            wr_load     = 1'($urandom_range(0, 1));
            wr_addr     = 5'($urandom);
            wr_data     = {$urandom, $urandom};
            tick();
            cycles++;
            if (last_req_fire) n++;
        end
        vectors++;
        if (n != 32 || cycles != 32) begin
            miscompares++;
            $display("FAIL stream_rate: got %0d reqs in %0d cycles want 32 in 32", n, cycles);
        end
        drain();
        lat_check = 1'b0;
    endtask

    task automatic test_random();
        wr_load = 1'b0;
        for (int c = 0; c < 300; c++) begin
            rd.req_valid = 1'($urandom_range(0, 1));
            rd.req_addr  = 5'($urandom);
            rd.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        rd.rsp_ready = 1'b0;
        rd.req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rd.req_addr = 5'($urandom);
            tick();
        end
        rd.req_valid = 1'b0;
        vectors++;
        if (rd.rsp_valid !== 1'b1 || rd.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_full: got v=%b rdy=%b want v=1 rdy=0", rd.rsp_valid, rd.req_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_async");
        model_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        rd.rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        rd.req_valid = 1'b1;
        rd.req_addr  = 5'd9;
        tick();
        drain();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        edge_cnt      = 0;
        max_inflight  = 0;
        lat_check     = 1'b0;
        last_req_fire = 1'b0;
        held_addr     = '0;
        held_data     = '0;
        test_reset();
        test_single_read();
        test_bypass();
        test_zero_reg();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
